// File: rtl/bcd_display_pkg.sv
// rtl/bcd_display_pkg.sv - shared widths, constants and BCD step helper for the counter display
package bcd_display_pkg;

    localparam int BCD_W     = 4;
    localparam int PRE_W     = 24;
    localparam int SEG_W     = 7;
    localparam int CFG_SHIFT = 10;

    // Returns {carry/borrow out, next digit}; the digit is untouched when cin is low.
    function automatic logic [BCD_W:0] bcd_step(
        input logic [BCD_W-1:0] digit,
        input logic             up,
        input logic             cin
    );
        logic [BCD_W:0] r;
        r = {1'b0, digit};
        if (cin) begin
            if (up) begin
                r = (digit >= BCD_W'(9)) ? {1'b1, BCD_W'(0)} : {1'b0, digit + BCD_W'(1)};
            end else begin
                r = (digit == BCD_W'(0)) ? {1'b1, BCD_W'(9)} : {1'b0, digit - BCD_W'(1)};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_counter_display_digit.sv
// rtl/bcd_counter_display_digit.sv - one BCD counter digit with carry/borrow chaining
module bcd_digit
    import bcd_display_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             clear,
    input  logic             step,
    input  logic             up,
    input  logic             cin,
    output logic [BCD_W-1:0] digit,
    output logic [BCD_W-1:0] digit_next,
    output logic             cout
);

    logic [BCD_W:0] stepped;

    assign stepped = bcd_step(digit, up, cin);
    assign cout    = stepped[BCD_W];

    // digit_next is what the register takes on the coming enabled edge; the scan
    // path uses it so segments follow a count change without a lag cycle.
    always_comb begin
        digit_next = digit;
        if (clear) begin
            digit_next = '0;
        end else if (step) begin
            digit_next = stepped[BCD_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit <= '0;
        end else if (ena) begin
            digit <= digit_next;
        end
    end

endmodule

// File: rtl/seg7.sv
// rtl/seg7.sv - BCD to seven-segment decoder, active-high {g,f,e,d,c,b,a}
module seg7
    import bcd_display_pkg::*;
(
    input  logic [BCD_W-1:0] digit,
    output logic [SEG_W-1:0] segments
);

    always_comb begin
        case (digit)
            4'd0:    segments = 7'h3F;
            4'd1:    segments = 7'h06;
            4'd2:    segments = 7'h5B;
            4'd3:    segments = 7'h4F;
            4'd4:    segments = 7'h66;
            4'd5:    segments = 7'h6D;
            4'd6:    segments = 7'h7D;
            4'd7:    segments = 7'h07;
            4'd8:    segments = 7'h7F;
            4'd9:    segments = 7'h6F;
            default: segments = 7'h00;
        endcase
    end

endmodule

// File: rtl/bcd_counter_display.sv
// rtl/bcd_counter_display.sv - N-digit BCD up/down counter with prescaler and multiplexed seven-segment scan
module bcd_counter_display
    import bcd_display_pkg::*;
#(
    parameter int               DIGITS        = 4,
    parameter logic [PRE_W-1:0] DEFAULT_COUNT = 24'd10_000_000,
    parameter int               SCAN_DIV      = 10_000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic [7:0]              cfg_compare,
    input  logic                    up_dn,
    input  logic                    hold,
    input  logic                    clear,
    input  logic                    blank_lz,
    output logic [BCD_W*DIGITS-1:0] value,
    output logic                    tick,
    output logic                    wrap,
    output logic [DIGITS-1:0]       digit_sel,
    output logic [SEG_W-1:0]        segments,
    output logic                    dp
);

    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [PRE_W-1:0]        pre_cnt;
    logic [PRE_W-1:0]        compare;
    logic [SCAN_W-1:0]       scan_cnt;
    logic                    scan_term;
    logic [IDX_W-1:0]        idx;
    logic [IDX_W-1:0]        idx_next;
    logic [DIGITS-1:0]       sel_next;
    logic                    step;
    logic [DIGITS:0]         carry;
    logic [BCD_W*DIGITS-1:0] value_next;
    logic [BCD_W-1:0]        shown_digit;
    logic [SEG_W-1:0]        shown_seg;
    logic                    blank;

    assign compare = (cfg_compare == 8'd0) ? DEFAULT_COUNT
                                           : (PRE_W'(cfg_compare) << CFG_SHIFT);
    assign step    = tick && !hold;
    assign carry[0] = 1'b1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .clk        (clk),
            .rst_n      (rst_n),
            .ena        (ena),
            .clear      (clear),
            .step       (step),
            .up         (up_dn),
            .cin        (carry[i]),
            .digit      (value[i*BCD_W +: BCD_W]),
            .digit_next (value_next[i*BCD_W +: BCD_W]),
            .cout       (carry[i+1])
        );
    end

    assign scan_term = (scan_cnt == SCAN_W'(SCAN_DIV - 1));

    always_comb begin
        idx_next = idx;
        if (scan_term) begin
            idx_next = (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
        end
    end

    always_comb begin
        sel_next           = '0;
        sel_next[idx_next] = 1'b1;
    end

    assign shown_digit = value_next[int'(idx_next)*BCD_W +: BCD_W];

    // A digit is blank when it and every digit above it are zero; digit 0 never is.
    always_comb begin
        logic zero_above;
        blank      = 1'b0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above && (value_next[i*BCD_W +: BCD_W] == BCD_W'(0));
            if (int'(idx_next) == i) begin
                blank = blank_lz && zero_above;
            end
        end
    end

    seg7 u_seg7 (
        .digit    (shown_digit),
        .segments (shown_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt   <= '0;
            tick      <= 1'b0;
            wrap      <= 1'b0;
            scan_cnt  <= '0;
            idx       <= '0;
            digit_sel <= DIGITS'(1);
            segments  <= 7'h3F;
            dp        <= 1'b0;
        end else if (ena) begin
            // >= rather than == so a lowered compare cannot strand pre_cnt above it.
            if (pre_cnt >= compare) begin
                pre_cnt <= '0;
                tick    <= 1'b1;
            end else begin
                pre_cnt <= pre_cnt + PRE_W'(1);
                tick    <= 1'b0;
            end
            wrap      <= !clear && step && carry[DIGITS];
            scan_cnt  <= scan_term ? '0 : scan_cnt + SCAN_W'(1);
            idx       <= idx_next;
            digit_sel <= sel_next;
            segments  <= blank ? '0 : shown_seg;
            dp        <= hold && (idx_next == '0);
        end else begin
            tick <= 1'b0;
            wrap <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bcd_counter_display.sv
// tb/tb_bcd_counter_display.sv - directed self-checking bench for bcd_counter_display
module tb_bcd_counter_display;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] cfg_compare;
    logic       up_dn;
    logic       hold;
    logic       clear;
    logic       blank_lz;
    logic [7:0] value;
    logic       tick;
    logic       wrap;
    logic [1:0] digit_sel;
    logic [6:0] segments;
    logic       dp;

    int checks = 0;
    int errors = 0;
    int n;
    int tick_seen;

    always #5 clk = ~clk;

    bcd_counter_display #(
        .DIGITS        (2),
        .DEFAULT_COUNT (24'd9),
        .SCAN_DIV      (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .cfg_compare (cfg_compare),
        .up_dn       (up_dn),
        .hold        (hold),
        .clear       (clear),
        .blank_lz    (blank_lz),
        .value       (value),
        .tick        (tick),
        .wrap        (wrap),
        .digit_sel   (digit_sel),
        .segments    (segments),
        .dp          (dp)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advances at least one negedge, stops on the first negedge with tick high.
    task automatic wait_tick(input int budget, input string tag, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!tick && cycles < budget);
        if (!tick) check({tag, "_timeout"}, tick, 1);
    endtask

    // Stops on the first negedge where the scan has just moved from digit 1 to digit 0.
    task automatic wait_phase(input string tag);
        logic [1:0] prev;
        logic       ok;
        int         k;
        prev = digit_sel;
        ok   = 1'b0;
        k    = 0;
        do begin
            @(negedge clk);
            ok   = (digit_sel == 2'b01) && (prev == 2'b10);
            prev = digit_sel;
            k++;
        end while (!ok && k < 20);
        if (!ok) check({tag, "_sync"}, ok, 1);
    endtask

    initial begin
        ena         = 1'b1;
        cfg_compare = 8'd0;
        up_dn       = 1'b1;
        hold        = 1'b0;
        clear       = 1'b0;
        blank_lz    = 1'b0;
        rst_n       = 1'b1;
        #1 rst_n    = 1'b0;
        #2;
        check("rst_value", value, 8'h00);
        check("rst_digit_sel", digit_sel, 2'b01);
        check("rst_tick", tick, 0);
        check("rst_wrap", wrap, 0);
        check("rst_segments", segments, 7'h3F);
        check("rst_dp", dp, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Default compare 9: tick every 10 cycles, first one 10 cycles after reset
        wait_tick(30, "first_tick", n);
        check("first_tick_latency", n, 10);
        @(negedge clk);
        check("tick_one_cycle", tick, 0);
        check("value_after_tick", value, 8'h01);
        wait_tick(30, "second_tick", n);
        check("tick_period", n, 9);
        repeat (10) wait_tick(30, "count_tick", n);
        @(negedge clk);
        check("value_12_ticks", value, 8'h12);

        // Hold: count frozen, ticks continue, dp lit on digit 0 only
        hold = 1'b1;
        wait_phase("hold");
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            check("hold_sel0", digit_sel, 2'b01);
            check("hold_dp0", dp, 1);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("hold_sel1", digit_sel, 2'b10);
            check("hold_dp1", dp, 0);
        end
        repeat (5) wait_tick(30, "hold_tick", n);
        @(negedge clk);
        check("hold_value", value, 8'h12);
        hold = 1'b0;

        // Down wrap from 00
        wait_tick(30, "align_tick", n);
        @(negedge clk);
        clear = 1'b1;
        up_dn = 1'b0;
        @(negedge clk);
        clear = 1'b0;
        check("clear_value", value, 8'h00);
        wait_tick(30, "down_tick", n);
        @(negedge clk);
        check("down_wrap_value", value, 8'h99);
        check("down_wrap_pulse", wrap, 1);
        @(negedge clk);
        check("down_wrap_one_cycle", wrap, 0);
        wait_tick(30, "down_tick2", n);
        @(negedge clk);
        check("down_value_98", value, 8'h98);
        up_dn = 1'b1;

        // Up wrap: 98 -> 99 -> 00
        wait_tick(30, "up_tick1", n);
        @(negedge clk);
        check("up_value_99", value, 8'h99);
        check("up_no_wrap", wrap, 0);
        wait_tick(30, "up_tick2", n);
        @(negedge clk);
        check("up_wrap_value", value, 8'h00);
        check("up_wrap_pulse", wrap, 1);
        @(negedge clk);
        check("up_wrap_one_cycle", wrap, 0);

        // Clear in the same cycle as a tick at 45
        repeat (45) wait_tick(30, "to45_tick", n);
        @(negedge clk);
        check("value_45", value, 8'h45);
        wait_tick(30, "clr_tick", n);
        check("clr_pre_value", value, 8'h45);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clr_tick_value", value, 8'h00);
        check("clr_tick_wrap", wrap, 0);

        // Scan with leading-zero blanking at 05
        repeat (5) wait_tick(30, "to05_tick", n);
        @(negedge clk);
        check("value_05", value, 8'h05);
        hold     = 1'b1;
        blank_lz = 1'b1;
        wait_phase("blank");
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            check("blank_sel0", digit_sel, 2'b01);
            check("blank_seg0", segments, 7'h6D);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("blank_sel1", digit_sel, 2'b10);
            check("blank_seg1", segments, 7'h00);
        end

        // Same display without blanking
        blank_lz = 1'b0;
        wait_phase("noblank");
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            check("noblank_sel0", digit_sel, 2'b01);
            check("noblank_seg0", segments, 7'h6D);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("noblank_sel1", digit_sel, 2'b10);
            check("noblank_seg1", segments, 7'h3F);
        end

        // cfg_compare = 1: compare 1024, ticks 1025 cycles apart
        cfg_compare = 8'd1;
        wait_tick(1100, "cfg1_tick", n);
        wait_tick(1100, "cfg1_tick2", n);
        check("cfg1_period", n, 1025);

        // Lower compare from 3072 to 1024 with pre_cnt at 2000
        cfg_compare = 8'd3;
        wait_tick(3200, "cfg3_tick", n);
        tick_seen = 0;
        repeat (2000) begin
            @(negedge clk);
            if (tick) tick_seen++;
        end
        check("cfg3_no_early_tick", tick_seen, 0);
        cfg_compare = 8'd1;
        @(negedge clk);
        check("lower_compare_tick", tick, 1);

        // Asynchronous reset mid-count at 37
        hold        = 1'b0;
        cfg_compare = 8'd0;
        clear       = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        repeat (37) wait_tick(30, "to37_tick", n);
        @(negedge clk);
        check("value_37", value, 8'h37);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_value", value, 8'h00);
        check("async_rst_digit_sel", digit_sel, 2'b01);
        check("async_rst_tick", tick, 0);
        check("async_rst_wrap", wrap, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_counter_display.md
# bcd_counter_display

Parameterised multi-digit BCD up/down counter with a programmable tick prescaler and a time-multiplexed seven-segment scan driver. It generalises the single-digit demo counter: N digits, count direction, hold/clear, leading-zero blanking and digit multiplexing. It sits between the top-level pin wrapper and the display pins. It reuses the existing `seg7` decoder for segment encoding.

## Interface
- `DIGITS`, default 4: number of BCD digits, range 1..8.
- `DEFAULT_COUNT`, default 24'd10_000_000: prescaler compare value used when `cfg_compare == 0`.
- `SCAN_DIV`, default 10_000: clock cycles each digit is displayed; must be ≥ 1.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ena`  in  1  global enable. When low, all state holds.
- `cfg_compare`  in  8  0 selects `DEFAULT_COUNT`; otherwise compare is `{6'b0, cfg_compare, 10'b0}`.
- `up_dn`  in  1  1 = count up, 0 = count down.
- `hold`  in  1  freeze the count. Prescaler and scan keep running.
- `clear`  in  1  synchronous clear of the count.
- `blank_lz`  in  1  enable leading-zero blanking.
- `value`  out  4*DIGITS  packed BCD count; digit 0 is in bits [3:0].
- `tick`  out  1  one-cycle pulse at each prescaler terminal count.
- `wrap`  out  1  one-cycle pulse when the count rolls over.
- `digit_sel`  out  DIGITS  one-hot, active-high select of the digit being driven.
- `segments`  out  7  `seg7` encoding of the selected digit; 0 when the digit is blanked.
- `dp`  out  1  decimal point.

## Operation
**Prescaler (24-bit `pre_cnt`)**
- If `pre_cnt >= compare`: `pre_cnt <= 0` and `tick <= 1`.
- Otherwise: `pre_cnt++` and `tick <= 0`.
- The `>=` test means lowering `cfg_compare` mid-count never causes a 2^24 overrun.
- Tick period is compare+1 cycles.

**Counter** (priority order, evaluated every `ena` cycle)
1. `clear`: all digits = 0, `wrap` = 0. Clear beats a simultaneous tick.
2. `tick && !hold && up_dn`: ripple-carry BCD increment. A digit at 9 becomes 0 and carries. All-9s becomes all-0s with `wrap` = 1.
3. `tick && !hold && !up_dn`: ripple-borrow BCD decrement. A digit at 0 becomes 9 and borrows. All-0s becomes all-9s with `wrap` = 1.
4. Otherwise: hold value, `wrap` = 0.
- Digits never leave the range 0..9.

**Scan**
- `scan_cnt` runs 0..SCAN_DIV-1.
- At terminal count, index `idx` advances 0→1→…→DIGITS-1→0 and `digit_sel` rotates left one bit.
- With `DIGITS` = 1, `digit_sel` stays at 1.

**Blanking**
- With `blank_lz` = 1, digit i > 0 is blanked (`segments` = 0) if it and every higher digit are 0.
- Digit 0 is never blanked.

**Decimal point**
- `dp` = `hold && (idx == 0)`: it marks a paused count on the least-significant digit.

**Enable**
- `ena` low freezes `pre_cnt`, `scan_cnt`, `idx` and the count.
- `tick` and `wrap` are forced to 0 while `ena` is low.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset values (asynchronous, on `rst_n` falling, held while low):
  - `value` = 0, `tick` = 0, `wrap` = 0, `dp` = 0.
  - `digit_sel` = 1 (digit 0).
  - `segments` = `seg7`(0).
  - `pre_cnt` = 0, `scan_cnt` = 0.
- `tick` is high in cycle T. `value` and `wrap` update on the edge ending cycle T, so they are visible in T+1.
- `digit_sel`, `segments` and `dp` change on the same edge, with no mixed-digit cycle.
- `segments` reflects a `value` change within 1 cycle, including mid-dwell.
- `clear`, `hold` and `up_dn` are sampled on every edge and take effect the next cycle.
- After `rst_n` is deasserted, the first tick occurs compare+1 enabled cycles later.

## Structure
- Shared package `bcd_display_pkg` holds:
  - `BCD_W` = 4 and `PRE_W` = 24.
  - The `cfg_compare` shift constant (10).
  - Function `bcd_step(digit, up, cin)` returning {cout, digit}.
- Sub-module `bcd_digit` is one digit with carry/borrow in and out. The top level instantiates `DIGITS` copies in a generate chain.
- One `seg7` instance is fed by the `value` mux at `idx`.

## Test plan
Bench parameters: `DIGITS` = 2, `DEFAULT_COUNT` = 9, `SCAN_DIV` = 4, `ena` = 1.
- **Reset:** assert `rst_n` low asynchronously mid-count at `value` = 0x37 → same cycle: `value` = 0x00, `digit_sel` = 01, `tick` = 0, `wrap` = 0.
- **Prescaler/count:** `cfg_compare` = 0, up → `tick` every 10 cycles; after 12 ticks `value` = 0x12.
- **Prescaler, configured compare:** `cfg_compare` = 1 → ticks 1025 cycles apart.
- **Up wrap:** from 0x98, up → 0x99, then 0x00 with `wrap` = 1 for exactly one cycle.
- **Down wrap:** from 0x00, `up_dn` = 0 → 0x99 with `wrap` = 1.
- **Hold:** `hold` = 1 for 5 ticks → `value` unchanged, `tick` still pulses, `dp` = 1 while `digit_sel` = 01.
- **Clear vs tick:** `clear` and `tick` in the same cycle at `value` = 0x45 → `value` = 0x00, `wrap` = 0.
- **Lower compare mid-count:** `cfg_compare` changes from 3 to 1 with `pre_cnt` = 2000 → `tick` on the next cycle.
- **Scan/blanking:** `value` = 0x05, `blank_lz` = 1 → `digit_sel` = 01 with `segments` = `seg7`(5) for 4 cycles, then `digit_sel` = 10 with `segments` = 0 for 4 cycles.
- **Scan, no blanking:** same setup with `blank_lz` = 0 → digit 1 shows `seg7`(0).
